// File: rtl/jmbl_drain4.sv
// jmbl_drain4: countdown loop; i steps I_START..0, sn decrements while i <= THRESH.
// Optional sticky underflow flag under `define JMBL_DRAIN4_UNDERFLOW_EN.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   start      in   launch request, sampled only in IDLE or DONE
//   sn_in      in   seed for sn, captured on an accepted start
//   i          out  loop index (registered)
//   sn         out  running accumulator (registered, floors at 0)
//   busy       out  high in LOAD or RUN
//   done       out  high in DONE
//   underflow  out  sticky: decrement requested while sn == 0
//                   (tied 0 unless JMBL_DRAIN4_UNDERFLOW_EN is defined)
module jmbl_drain4 #(
    parameter int WIDTH   = 11,
    parameter int I_START = 251,
    parameter int THRESH  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sn_in,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] sn,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] IS = WIDTH'(I_START);
    localparam logic [WIDTH-1:0] TH = WIDTH'(THRESH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] sn_q, sn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef JMBL_DRAIN4_UNDERFLOW_EN
    logic             uf_q, uf_d;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        sn_d    = sn_q;
`ifdef JMBL_DRAIN4_UNDERFLOW_EN
        uf_d    = uf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    i_d     = IS;
                    sn_d    = sn_in;
`ifdef JMBL_DRAIN4_UNDERFLOW_EN
                    uf_d    = 1'b0;
`endif
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                // i is always >= 1 here, so the decrement cannot wrap.
                i_d = i_q - ONE;
                if (i_q <= TH) begin
                    if (sn_q != '0) begin
                        sn_d = sn_q - ONE;
                    end else begin
`ifdef JMBL_DRAIN4_UNDERFLOW_EN
                        uf_d = 1'b1;
`endif
                    end
                end
                if (i_q == ONE) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state.
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            sn_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            sn_q    <= sn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef JMBL_DRAIN4_UNDERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            uf_q <= 1'b0;
        end else begin
            uf_q <= uf_d;
        end
    end

    assign underflow = uf_q;
`else
    assign underflow = 1'b0;
`endif

    assign i    = i_q;
    assign sn   = sn_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_jmbl_drain4.sv
// tb_jmbl_drain4: directed table of runs plus hand-written
// sequences for ignored restart, mid-run reset and held start.
module tb_jmbl_drain4;

    localparam int W  = 11;
    localparam int IS = 251;
    localparam int TH = 150;
    localparam int LAT = IS + 1;

`ifdef JMBL_DRAIN4_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] sn_in;
    logic [W-1:0] i;
    logic [W-1:0] sn;
    logic         busy;
    logic         done;
    logic         underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] sn_in;
        logic [W-1:0] sn;
        bit           uf;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    jmbl_drain4 #(
        .WIDTH  (W),
        .I_START(IS),
        .THRESH (TH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sn_in    (sn_in),
        .i        (i),
        .sn       (sn),
        .busy     (busy),
        .done     (done),
        .underflow(underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges after the accepting edge until done rises.
    task automatic wait_done(output int k, input bit mon,
                             input logic [W-1:0] s);
        k = 0;
        while (!done && k < 300) begin
            step();
            k++;
            if (mon) begin
                chk("mon_sn_le_in", 32'(sn <= s), 1);
                chk("mon_i_le_start", 32'(i <= W'(IS)), 1);
            end
        end
    endtask

    task automatic run_one(input logic [W-1:0] s,
                           input logic [W-1:0] esn, input bit euf);
        int k;
        sn_in = s;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_done", done, 0);
        chk("acc_i", i, IS);
        chk("acc_sn", sn, s);
        chk("acc_uf", underflow, 0);
        wait_done(k, 1'b0, s);
        chk("latency", k, LAT);
        chk("end_i", i, 0);
        chk("end_sn", sn, esn);
        chk("end_uf", underflow, euf);
        chk("end_busy", busy, 0);
        step();
        chk("hold_done", done, 1);
        chk("hold_sn", sn, esn);
        chk("hold_i", i, 0);
    endtask

    initial begin
        int k;

        tbl[0] = '{11'd200,  11'd50,   1'b0};
        tbl[1] = '{11'd150,  11'd0,    1'b0};
        tbl[2] = '{11'd100,  11'd0,    UF_EN};
        tbl[3] = '{11'd200,  11'd50,   1'b0};
        tbl[4] = '{11'd0,    11'd0,    UF_EN};
        tbl[5] = '{11'd151,  11'd1,    1'b0};
        tbl[6] = '{11'd2047, 11'd1897, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        sn_in = '0;
        step();
        step();
        chk("rst_i", i, 0);
        chk("rst_sn", sn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_uf", underflow, 0);

        // start coincident with rst is dropped
        start = 1'b1;
        sn_in = 11'd77;
        step();
        chk("rst_start_busy", busy, 0);
        chk("rst_start_sn", sn, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        for (int v = 0; v < 7; v++) begin
            run_one(tbl[v].sn_in, tbl[v].sn, tbl[v].uf);
        end

        // restart attempt mid-run, then reset mid-run
        sn_in = 11'd300;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (i != 11'd200 && k < 300) begin
            step();
            k++;
        end
        chk("t5_i200", i, 200);
        start = 1'b1;
        sn_in = 11'd5;
        step();
        start = 1'b0;
        chk("t5_ignored_i", i, 199);
        chk("t5_ignored_busy", busy, 1);
        chk("t5_ignored_sn", sn, 300);
        k = 0;
        while (i != 11'd120 && k < 300) begin
            step();
            k++;
        end
        chk("t5_i120", i, 120);
        chk("t5_sn_mid", sn, 270);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_i", i, 0);
        chk("t5_rst_sn", sn, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        step();
        chk("t5_idle_busy", busy, 0);

        // start held high: back-to-back runs
        sn_in = 11'd400;
        start = 1'b1;
        step();
        for (int r = 0; r < 2; r++) begin
            wait_done(k, 1'b1, 11'd400);
            chk("t6_latency", k, LAT);
            chk("t6_done", done, 1);
            chk("t6_sn", sn, 250);
            chk("t6_i", i, 0);
            step();
            chk("t6_reload_done", done, 0);
            chk("t6_reload_busy", busy, 1);
            chk("t6_reload_i", i, IS);
            chk("t6_reload_sn", sn, 400);
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
